// File: rtl/demux_1_8_deser.sv
// demux_1_8_deser: sequential 1:8 demultiplexer / deserializer.
// Serial bits fill one slot per valid edge. A completed word moves to a
// valid/ready holding register. The running slot index is exported so an
// upstream 8:1 mux can use it as its select.
// Optional build macro: DEMUX_MSB_FIRST_EN. When defined, slot k maps to
// dout[WIDTH-1-k]. When undefined, slot k maps to dout[k].
// WIDTH must be a power of two (>= 2), and 2**SEL_W must equal WIDTH.
module demux_1_8_deser #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] slot,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             misalign
);

`ifdef DEMUX_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] r_slot;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             r_misalign;

  logic             w_take_sync;
  logic             w_take_bit;
  logic             w_complete;
  logic             w_misalign;
  logic [SEL_W-1:0] w_slot_next;
  logic [WIDTH-1:0] w_asm_next;
  logic [WIDTH-1:0] w_bit_hit;

  // A sync is only honoured together with a valid bit. It restarts the frame.
  assign w_take_sync = din_valid & sync;
  assign w_take_bit  = din_valid & ~sync;
  // The word completes when a plain data bit lands in the last slot.
  assign w_complete  = w_take_bit & (r_slot == LAST_SLOT);
  assign w_misalign  = w_take_sync & (r_slot != '0);

  // The slot index advances on every accepted bit and wraps naturally at WIDTH.
  // A sync forces it to 1, because slot 0 is consumed by the sync bit itself.
  always_comb begin
    w_slot_next = r_slot;
    if (w_take_sync) begin
      w_slot_next = SEL_W'(1);
    end else if (w_take_bit) begin
      w_slot_next = r_slot + SEL_W'(1);
    end
  end

  // Per-bit next value of the assembly register. Each dout bit position knows
  // which slot feeds it. The ordering macro only changes that mapping.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      localparam int BIT_SLOT = MSB_FIRST ? (WIDTH - 1 - gi) : gi;
      localparam bit IS_FIRST = (BIT_SLOT == 0);
      assign w_bit_hit[gi]  = (r_slot == SEL_W'(BIT_SLOT));
      assign w_asm_next[gi] = w_take_sync ? (IS_FIRST ? din : 1'b0) :
                              (w_take_bit && w_bit_hit[gi]) ? din : r_asm[gi];
    end
  endgenerate

  // Capture path: the slot counter and the assembly register. Neither stalls
  // on backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
      r_asm  <= '0;
    end else begin
      r_slot <= w_slot_next;
      r_asm  <= w_asm_next;
    end
  end

  // Holding register and handshake. A completed word loads if the holder is
  // free, or is being drained this edge. Otherwise the word is dropped and
  // overrun is flagged, and the flag stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_complete) begin
      if (!r_dout_valid || dout_ready) begin
        r_dout       <= w_asm_next;
        r_dout_valid <= 1'b1;
      end else begin
        r_overrun    <= 1'b1;
      end
    end else if (r_dout_valid && dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  // One-cycle pulse when a sync interrupts a partially assembled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
    end
  end

  assign slot       = r_slot;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Testbench for demux_1_8_deser: directed scenarios followed by a random phase.
// All outputs are compared against a queue-based frame model after every edge.
// The bit ordering follows DEMUX_MSB_FIRST_EN, as the design does.
module tb_demux_1_8_deser;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             sync;
  logic [SEL_W-1:0] slot;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             misalign;

  int total = 0;
  int bad   = 0;

  // Reference model state: the bits collected so far in the current frame.
  logic             m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_dv;
  logic             m_ov;
  logic             m_mis;

  demux_1_8_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .slot       (slot),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // Maps the arrival index of a bit within a frame to its dout position.
  function automatic int pos_of(input int k);
`ifdef DEMUX_MSB_FIRST_EN
    return WIDTH - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".slot"},     32'(slot),       32'(m_q.size() % WIDTH));
    chk({tag, ".dout"},     32'(dout),       32'(m_dout));
    chk({tag, ".dv"},       32'(dout_valid), 32'(m_dv));
    chk({tag, ".overrun"},  32'(overrun),    32'(m_ov));
    chk({tag, ".misalign"}, 32'(misalign),   32'(m_mis));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ov   = 1'b0;
    m_mis  = 1'b0;
  endtask

  // Drives one cycle, advances the model by the rules of a single edge, and
  // checks every output 1 time unit after the edge.
  task automatic step(input logic b, input logic v, input logic s, input logic rdy,
                      input string tag);
    logic             compl;
    logic [WIDTH-1:0] word;
    din = b; din_valid = v; sync = s; dout_ready = rdy;
    @(posedge clk);
    compl = 1'b0;
    word  = '0;
    m_mis = 1'b0;
    if (v) begin
      if (s) begin
        m_mis = (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(b);
      end else begin
        m_q.push_back(b);
        if (m_q.size() == WIDTH) begin
          compl = 1'b1;
          for (int k = 0; k < WIDTH; k++) word[pos_of(k)] = m_q[k];
          m_q.delete();
        end
      end
    end
    if (compl) begin
      if (!m_dv || rdy) begin
        m_dout = word;
        m_dv   = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_dv && rdy) begin
      m_dv = 1'b0;
    end
    #1;
    check_all(tag);
    $display("step %-10s din=%0b v=%0b s=%0b rdy=%0b -> slot=%0d dout=%h dv=%0b ov=%0b mis=%0b",
             tag, b, v, s, rdy, slot, dout, dout_valid, overrun, misalign);
  endtask

  // Sends a word whose final dout value is w. The ready level on the last
  // bit can differ from the rest, and gap inserts an idle cycle between bits.
  // The idle cycles carry sync=1, which must be ignored.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic sync_first,
                           input logic rdy, input logic rdy_last, input logic gap,
                           input string tag);
    for (int k = 0; k < WIDTH; k++) begin
      step(w[pos_of(k)], 1'b1, (k == 0) && sync_first,
           (k == WIDTH - 1) ? rdy_last : rdy, tag);
      if (gap && k != WIDTH - 1) step(1'b1, 1'b0, 1'b1, rdy, {tag, "_gap"});
    end
  endtask

  // Asserts reset between clock edges and checks that it takes effect at once.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_imm"});
    @(posedge clk);
    #1 rst = 1'b0;
    check_all({tag, "_rel"});
    $display("reset %s done", tag);
  endtask

  initial begin
    logic [WIDTH-1:0] raw;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: the first word is sent with sync on its first bit. Bits 1,0,1,0,0,1,0,1
    // are palindromic, so dout reads A5 in either ordering.
    send_word(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, "t1_a5");
    chk("t1_a5_const", 32'(dout), 32'hA5);
    chk("t1_a5_dv", 32'(dout_valid), 32'h1);
    raw = 8'h01;
    for (int k = 0; k < WIDTH; k++) step(raw[k], 1'b1, 1'b0, 1'b1, "t1_raw");
`ifdef DEMUX_MSB_FIRST_EN
    chk("t1_raw_const", 32'(dout), 32'h80);
`else
    chk("t1_raw_const", 32'(dout), 32'h01);
`endif

    // 2: gapped input. The slot advances only on valid edges.
    send_word(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, "t2_3c");
    chk("t2_3c_const", 32'(dout), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t2_drain");

    // 3: backpressure. The second word is dropped and overrun is set.
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, "t3_11");
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, "t3_22");
    chk("t3_hold_const", 32'(dout), 32'h11);
    chk("t3_ov_const", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "t3_drain");
    chk("t3_dv_drop", 32'(dout_valid), 32'h0);

    // 4: a word completes on the edge where the held word is consumed.
    async_reset("t4_rst");
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, "t4_11");
    send_word(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, "t4_22");
    chk("t4_dout_const", 32'(dout), 32'h22);
    chk("t4_dv_const", 32'(dout_valid), 32'h1);
    chk("t4_ov_const", 32'(overrun), 32'h0);

    // 5: sync arrives after 3 bits. The partial word is discarded.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1, "t5_pre");
    step(1'b1, 1'b1, 1'b1, 1'b1, "t5_sync");
    chk("t5_mis_const", 32'(misalign), 32'h1);
    chk("t5_slot_const", 32'(slot), 32'h1);
    chk("t5_dv_const", 32'(dout_valid), 32'h0);
    for (int k = 0; k < WIDTH - 1; k++) step(1'b0, 1'b1, 1'b0, 1'b1, "t5_post");
    chk("t5_word_dv", 32'(dout_valid), 32'h1);
`ifdef DEMUX_MSB_FIRST_EN
    chk("t5_word_const", 32'(dout), 32'h80);
`else
    chk("t5_word_const", 32'(dout), 32'h01);
`endif

    // 6: async reset mid-word, then a fresh word.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "t6_pre");
    async_reset("t6_rst");
    send_word(8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, "t6_f0");
    chk("t6_f0_const", 32'(dout), 32'hF0);

    // Random phase.
    async_reset("rnd_rst");
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7),
           "rnd");
      if (i == 750) async_reset("rnd_mid");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
